// File: rtl/status_flags.sv
// 6502 processor status register: ALU flag capture, PLP/RTI loads, flag ops, push image, delayed I and registered branch evaluation.
// Define STATUS_FLAGS_DECIMAL_EN to store the D flag; otherwise D reads as 0 and CLD/SED are no-ops.
module status_flags #(
    parameter logic [7:0] RESET_P = 8'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       upd_en,
    input  logic [3:0] upd_mask,
    input  logic       bit_en,
    input  logic [7:0] bus_in,
    input  logic       load_en,
    input  logic       flag_op_en,
    input  logic [2:0] flag_op,
    input  logic       push_b,
    input  logic       instr_done,
    input  logic       br_req,
    input  logic [2:0] br_cond,
    output logic [7:0] p_out,
    output logic       carry_out,
    output logic       overflow_out,
    output logic       irq_mask,
    output logic       br_valid,
    output logic       br_taken
);

    typedef enum logic [2:0] {
        OP_CLC = 3'd0,
        OP_SEC = 3'd1,
        OP_CLI = 3'd2,
        OP_SEI = 3'd3,
        OP_CLV = 3'd4,
        OP_CLD = 3'd5,
        OP_SED = 3'd6,
        OP_NOP = 3'd7
    } flag_op_e;

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, i_d, z_d, c_d;
    logic flag_sel;
    logic cond_met;

`ifdef STATUS_FLAGS_DECIMAL_EN
    logic d_d;
    logic unused_bus;
    assign unused_bus = ^bus_in[5:4];
`else
    logic unused_bus;
    assign unused_bus = ^bus_in[5:3];
    assign d_q        = 1'b0;
`endif

    // Single highest-priority write source: load > flag op > BIT > ALU update
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;
`ifdef STATUS_FLAGS_DECIMAL_EN
        d_d = d_q;
`endif
        if (load_en) begin
            n_d = bus_in[7];
            v_d = bus_in[6];
            i_d = bus_in[2];
            z_d = bus_in[1];
            c_d = bus_in[0];
`ifdef STATUS_FLAGS_DECIMAL_EN
            d_d = bus_in[3];
`endif
        end else if (flag_op_en) begin
            case (flag_op_e'(flag_op))
                OP_CLC: c_d = 1'b0;
                OP_SEC: c_d = 1'b1;
                OP_CLI: i_d = 1'b0;
                OP_SEI: i_d = 1'b1;
                OP_CLV: v_d = 1'b0;
`ifdef STATUS_FLAGS_DECIMAL_EN
                OP_CLD: d_d = 1'b0;
                OP_SED: d_d = 1'b1;
`endif
                default: ;
            endcase
        end else if (bit_en) begin
            n_d = bus_in[7];
            v_d = bus_in[6];
            z_d = alu_z;
        end else if (upd_en) begin
            if (upd_mask[3]) n_d = alu_n;
            if (upd_mask[2]) v_d = alu_v;
            if (upd_mask[1]) z_d = alu_z;
            if (upd_mask[0]) c_d = alu_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= RESET_P[7];
            v_q <= RESET_P[6];
            i_q <= RESET_P[2];
            z_q <= RESET_P[1];
            c_q <= RESET_P[0];
        end else begin
            n_q <= n_d;
            v_q <= v_d;
            i_q <= i_d;
            z_q <= z_d;
            c_q <= c_d;
        end
    end

`ifdef STATUS_FLAGS_DECIMAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= RESET_P[3];
        else        d_q <= d_d;
    end
`endif

    // Mask follows the post-write I so CLI/SEI/PLP take effect after the instruction completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          irq_mask <= 1'b1;
        else if (instr_done) irq_mask <= i_d;
    end

    always_comb begin
        case (br_cond[2:1])
            2'b00:   flag_sel = n_q;
            2'b01:   flag_sel = v_q;
            2'b10:   flag_sel = c_q;
            default: flag_sel = z_q;
        endcase
        cond_met = (flag_sel == br_cond[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            br_valid <= br_req;
            if (br_req) br_taken <= cond_met;
        end
    end

    assign p_out        = {n_q, v_q, 1'b1, push_b, d_q, i_q, z_q, c_q};
    assign carry_out    = c_q;
    assign overflow_out = v_q;

endmodule

// File: tb/tb_status_flags.sv
// Self-checking bench for status_flags: directed scenarios then randomized traffic against a byte-level model of P.
module tb_status_flags;

`ifdef STATUS_FLAGS_DECIMAL_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif
    localparam logic [7:0] PMASK = DEC ? 8'hCF : 8'hC7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_n, alu_v, alu_z, alu_c;
    logic       upd_en;
    logic [3:0] upd_mask;
    logic       bit_en;
    logic [7:0] bus_in;
    logic       load_en;
    logic       flag_op_en;
    logic [2:0] flag_op;
    logic       push_b;
    logic       instr_done;
    logic       br_req;
    logic [2:0] br_cond;
    logic [7:0] p_out;
    logic       carry_out, overflow_out, irq_mask, br_valid, br_taken;

    status_flags dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_n        (alu_n),
        .alu_v        (alu_v),
        .alu_z        (alu_z),
        .alu_c        (alu_c),
        .upd_en       (upd_en),
        .upd_mask     (upd_mask),
        .bit_en       (bit_en),
        .bus_in       (bus_in),
        .load_en      (load_en),
        .flag_op_en   (flag_op_en),
        .flag_op      (flag_op),
        .push_b       (push_b),
        .instr_done   (instr_done),
        .br_req       (br_req),
        .br_cond      (br_cond),
        .p_out        (p_out),
        .carry_out    (carry_out),
        .overflow_out (overflow_out),
        .irq_mask     (irq_mask),
        .br_valid     (br_valid),
        .br_taken     (br_taken)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Model: stored flags as a P byte (bits 5:4 kept 0), plus mask and branch result
    logic [7:0] m_p;
    logic       m_irq, m_valid, m_taken;

    int unsigned op_bit [7] = '{0, 0, 2, 2, 6, 3, 3};
    bit          op_val [7] = '{0, 1, 0, 1, 0, 0, 1};
    int unsigned br_pos [4] = '{7, 6, 0, 1};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        alu_n = 0; alu_v = 0; alu_z = 0; alu_c = 0;
        upd_en = 0; upd_mask = '0; bit_en = 0; bus_in = '0;
        load_en = 0; flag_op_en = 0; flag_op = '0; push_b = 0;
        instr_done = 0; br_req = 0; br_cond = '0;
    endtask

    task automatic check_all();
        check("p_out", p_out, m_p | 8'h20 | {3'b000, push_b, 4'b0000});
        check("carry_out", {7'b0, carry_out}, {7'b0, m_p[0]});
        check("overflow_out", {7'b0, overflow_out}, {7'b0, m_p[6]});
        check("irq_mask", {7'b0, irq_mask}, {7'b0, m_irq});
        check("br_valid", {7'b0, br_valid}, {7'b0, m_valid});
        check("br_taken", {7'b0, br_taken}, {7'b0, m_taken});
    endtask

    task automatic model_edge();
        logic [7:0] nxt;
        logic [7:0] mk;
        nxt = m_p;
        m_valid = br_req;
        if (br_req) m_taken = (m_p[br_pos[br_cond[2:1]]] == br_cond[0]);
        if (load_en)
            nxt = bus_in;
        else if (flag_op_en) begin
            if (flag_op != 3'd7) nxt[op_bit[flag_op]] = op_val[flag_op];
        end else if (bit_en) begin
            nxt[7] = bus_in[7];
            nxt[6] = bus_in[6];
            nxt[1] = alu_z;
        end else if (upd_en) begin
            mk  = {upd_mask[3], upd_mask[2], 4'b0000, upd_mask[1], upd_mask[0]};
            nxt = (nxt & ~mk) | ({alu_n, alu_v, 4'b0000, alu_z, alu_c} & mk);
        end
        nxt = nxt & PMASK;
        if (instr_done) m_irq = nxt[2];
        m_p = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    // Asserted mid-cycle, away from the clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        m_p = 8'h04 & PMASK; m_irq = 1; m_valid = 0; m_taken = 0;
        check_all();
        check("rst_p_pb0", p_out, 8'h24);
        push_b = 1'b1;
        #1;
        check("rst_p_pb1", p_out, 8'h34);
        push_b = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        #1;
        do_reset();

        // ADC-style full update, then partial mask
        upd_en = 1; upd_mask = 4'b1111; alu_n = 1; alu_v = 1; alu_z = 0; alu_c = 1;
        step();
        check("adc_p", p_out, 8'hE5);
        upd_mask = 4'b1010; alu_n = 0; alu_z = 1;
        step();
        check("adc_mask_p", p_out, 8'h67);

        // Load beats flag op and ALU update
        clear_inputs();
        load_en = 1; bus_in = 8'hFF; flag_op_en = 1; flag_op = 3'd0; upd_en = 1; upd_mask = 4'b1111;
        step();
        check("prio_p", p_out, DEC ? 8'hEF : 8'hE7);

        // BIT: N/V from operand, Z from ALU, C held
        clear_inputs();
        bus_in = 8'h80; alu_z = 1; bit_en = 1; alu_c = 0;
        step();
        check("bit_p", p_out & 8'hC3, 8'h83);

        // CLI without instr_done keeps the mask; completion applies it
        clear_inputs();
        flag_op_en = 1; flag_op = 3'd2;
        step();
        check("cli_hold", {7'b0, irq_mask}, 8'h01);
        clear_inputs();
        instr_done = 1;
        step();
        check("cli_apply", {7'b0, irq_mask}, 8'h00);

        // Branch sees flags from before a same-cycle write
        clear_inputs();
        upd_en = 1; upd_mask = 4'b0010; alu_z = 0;
        step();
        br_req = 1; br_cond = 3'd7; alu_z = 1;
        step();
        check("beq_stale", {6'b0, br_valid, br_taken}, 8'h02);
        clear_inputs();
        br_req = 1; br_cond = 3'd7;
        step();
        check("beq_taken", {6'b0, br_valid, br_taken}, 8'h03);
        clear_inputs();
        step();
        check("br_idle", {6'b0, br_valid, br_taken}, 8'h01);

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            alu_n      = 1'($urandom);
            alu_v      = 1'($urandom);
            alu_z      = 1'($urandom);
            alu_c      = 1'($urandom);
            upd_en     = ($urandom_range(0, 1) == 0);
            upd_mask   = 4'($urandom);
            bit_en     = ($urandom_range(0, 5) == 0);
            bus_in     = 8'($urandom);
            load_en    = ($urandom_range(0, 7) == 0);
            flag_op_en = ($urandom_range(0, 3) == 0);
            flag_op    = 3'($urandom_range(0, 7));
            push_b     = 1'($urandom);
            instr_done = ($urandom_range(0, 2) == 0);
            br_req     = ($urandom_range(0, 2) != 0);
            br_cond    = 3'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/status_flags.md
Name: status_flags

Overview:
- Processor status register (P) for the 6502 core; sits directly downstream of the ALU.
- Captures the ALU's N/V/Z/C outputs under control-unit masks.
- Feeds C and V back to the ALU carry/overflow inputs.
- Provides the push image for PHP/BRK/IRQ, loads from the bus for PLP/RTI, executes flag instructions, and evaluates branch conditions with a registered result.

Parameters:
- RESET_P, 8'h04, reset value of stored flags {N,V,0,0,D,I,Z,C}; bits 5:4 ignored.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_n / alu_v / alu_z / alu_c  input  1 each  ALU flag outputs
- upd_en  input  1  capture ALU flags this cycle
- upd_mask  input  4  per-flag capture enable: [3]=N [2]=V [1]=Z [0]=C
- bit_en  input  1  BIT instruction update
- bus_in  input  8  data bus (PLP/RTI image, BIT operand)
- load_en  input  1  load P from bus_in
- flag_op_en  input  1  execute flag_op
- flag_op  input  3  0 CLC, 1 SEC, 2 CLI, 3 SEI, 4 CLV, 5 CLD, 6 SED, 7 reserved/no-op
- push_b  input  1  B bit value for the push image (1 for PHP/BRK, 0 for IRQ/NMI)
- instr_done  input  1  pulse at the last cycle of each instruction
- br_req  input  1  evaluate branch condition
- br_cond  input  3  0 BPL, 1 BMI, 2 BVC, 3 BVS, 4 BCC, 5 BCS, 6 BNE, 7 BEQ
- p_out  output  8  {N,V,1,push_b,D,I,Z,C}, combinational from stored flags
- carry_out  output  1  stored C, to ALU carryIn
- overflow_out  output  1  stored V, to ALU overflowIn
- irq_mask  output  1  effective interrupt mask
- br_valid  output  1  branch result valid, one-cycle pulse
- br_taken  output  1  branch decision

Behaviour:
- Flags N, V, D, I, Z, C are registers. Bits 5 and 4 are not stored.
- Reset (async, rst_n=0): flags=RESET_P (I=1, rest 0 by default); irq_mask=1; br_valid=0; br_taken=0. Reset is honoured mid-instruction and mid-branch-evaluation; any pending br_valid is dropped.
- Write sources, applied on the rising edge. Only the single highest-priority asserted source acts in a cycle: load_en > flag_op_en > bit_en > upd_en.
  - load_en: N,V,D,I,Z,C <= bus_in[7,6,3,2,1,0]; bus_in[5:4] discarded.
  - flag_op_en: modifies only the named flag; code 7 changes nothing.
  - bit_en: N<=bus_in[7], V<=bus_in[6], Z<=alu_z; C, D, I unchanged.
  - upd_en: for each set upd_mask bit, the flag <= the corresponding alu_* input. Cleared mask bits hold. upd_mask=0 is a legal no-op.
- carry_out and overflow_out reflect stored flags only; no combinational path from alu_* inputs.
- irq_mask implements the delayed I effect: irq_mask <= I (post-update value) on each cycle with instruction_done asserted, i.e. the cycle instr_done=1 samples I including any same-cycle write. Otherwise it holds. CLI/SEI/PLP therefore affect interrupt sampling only after the next instruction completes.
- Branch evaluation: br_req sampled at edge k. At edge k+1, br_valid=1 and br_taken reflects flags as stored before edge k, so a same-cycle flag write is not seen. br_valid returns to 0 unless br_req was also asserted at edge k+1. Back-to-back br_req gives one result per cycle. When br_valid=0, br_taken holds its last value.
- Condition encoding: br_cond[2:1] selects the flag (00 N, 01 V, 10 C, 11 Z); br_cond[0] is the required flag value.

Optional Feature:
- Macro: STATUS_FLAGS_DECIMAL_EN.
- Defined: D is a real register, writable by CLD/SED and load_en, and visible in p_out[3].
- Undefined: D is tied to 0. CLD/SED are no-ops; load_en ignores bus_in[3]; p_out[3]=0. This is the decimal-less ALU build.

Test Plan:
- Reset: rst_n low asynchronously mid-cycle -> p_out=8'h24 with push_b=0 (8'h34 with push_b=1); irq_mask=1; br_valid=0.
- ADC-style update: upd_en=1, upd_mask=4'b1111, alu_n=1, alu_v=1, alu_z=0, alu_c=1 -> next cycle p_out=8'hE5 (push_b=0, I=1); carry_out=1; overflow_out=1. Then upd_mask=4'b1010, alu_n=0, alu_z=1 -> p_out=8'h67.
- Priority: load_en=1, bus_in=8'hFF, flag_op_en=1 (CLC), upd_en=1 all in the same cycle -> load wins: p_out=8'hEF (decimal build) or 8'hE7 (non-decimal); bits 5:4 follow 1/push_b, not bus_in.
- BIT: bus_in=8'h80, alu_z=1, bit_en=1, with C=1 beforehand -> N=1, V=0, Z=1, C stays 1.
- Delayed CLI: I=1, flag_op=CLI with instr_done=0 -> irq_mask stays 1. Next cycle instr_done=1 -> irq_mask=0 one edge later.
- Branch pipeline: Z=0; br_req with BEQ while upd_en sets Z=1 the same cycle -> next cycle br_valid=1, br_taken=0. Following br_req with BEQ -> br_taken=1. Idle -> br_valid=0.
